// File: rtl/d_mem_arbiter.sv
// Purpose: shares the single-port data memory between the load/store port (0) and the string/DMA port (1), round-robin on ties.
// Latency: request sampled in IDLE -> memory strobe next cycle -> ack/err the cycle after; one transaction per 3 cycles.
// Backpressure: level req/ack handshake; a master holds req/we/addr/wdata until its ack, and requests are only sampled in IDLE.
//
// Ports:
//   clock, reset_n           single clock, asynchronous active-low reset
//   req/we/addr/wdata{0,1}   per-port transaction request (byte address, 1 = write)
//   ack/err/rdata{0,1}       one-cycle completion pulse, rejection flag, registered read data
//   MemRead/MemWrite         one-cycle memory strobes, only in the ACCESS cycle of a legal address
//   Address/WriteData        memory address/data, zero outside ACCESS
//   ReadData                 asynchronous memory read data, only looked at in ACCESS
module d_mem_arbiter #(
    parameter int MEM_SIZE = 256
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] Address,
    output logic [31:0] WriteData,
    input  logic [31:0] ReadData
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // Port served by the most recent grant; the other port wins the next tie.
    logic        last;
    logic        owner;
    logic        lat_we;
    logic        lat_err;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic        grant_vld;
    logic        grant_port;
    logic        sel_we;
    logic        sel_err;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;

    // Request of the port being granted this cycle, and its address check.
    always_comb begin
        sel_we    = grant_port ? we1    : we0;
        sel_addr  = grant_port ? addr1  : addr0;
        sel_wdata = grant_port ? wdata1 : wdata0;
        sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr[31:2] >= 30'(MEM_SIZE));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        grant_vld  = 1'b0;
        grant_port = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        Address    = '0;
        WriteData  = '0;
        ack0       = 1'b0;
        ack1       = 1'b0;
        err0       = 1'b0;
        err1       = 1'b0;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    grant_vld  = 1'b1;
                    grant_port = ~last;
                end else if (req0) begin
                    grant_vld  = 1'b1;
                    grant_port = 1'b0;
                end else if (req1) begin
                    grant_vld  = 1'b1;
                    grant_port = 1'b1;
                end
                if (grant_vld) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                // Rejected addresses still walk through ACCESS so every
                // transaction costs the same three cycles, but never strobe.
                MemWrite  = lat_we  && !lat_err;
                MemRead   = !lat_we && !lat_err;
                Address   = lat_addr;
                WriteData = lat_wdata;
                state_nxt = RESP;
            end
            RESP: begin
                ack0      = !owner;
                ack1      = owner;
                err0      = !owner && lat_err;
                err1      = owner && lat_err;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last      <= 1'b1;
            owner     <= 1'b0;
            lat_we    <= 1'b0;
            lat_err   <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            if (grant_vld) begin
                last      <= grant_port;
                owner     <= grant_port;
                lat_we    <= sel_we;
                lat_err   <= sel_err;
                lat_addr  <= sel_addr;
                lat_wdata <= sel_wdata;
            end
            // Only a legal read updates the owner's data; writes and
            // rejected reads leave the last good read visible.
            if (state == ACCESS && !lat_we && !lat_err) begin
                if (owner) begin
                    rdata1 <= ReadData;
                end else begin
                    rdata0 <= ReadData;
                end
            end
        end
    end

endmodule
